// File: rtl/inv_key_schedule.sv
// Inverse AES-128 key schedule: starting from the round-NR key, emits round
// keys NR down to 0 over a valid/ready interface, one per accepted handshake.
module inv_key_schedule #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] last_key,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_index,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Forward AES S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t         state_q;
  logic [127:0]   rk_data_q;
  logic [3:0]     rk_index_q;
  logic           rk_valid_q;
  logic           done_q;
  logic           busy_q;

  logic [31:0]    a0, a1, a2, a3;
  logic [31:0]    b0, b1, b2, b3;
  logic [127:0]   prev_key_d;

  // Previous round key is derived straight from the current register.
  assign a0 = rk_data_q[127:96];
  assign a1 = rk_data_q[95:64];
  assign a2 = rk_data_q[63:32];
  assign a3 = rk_data_q[31:0];
  assign b3 = a3 ^ a2;
  assign b2 = a2 ^ a1;
  assign b1 = a1 ^ a0;
  assign b0 = a0 ^ sub_word({b3[23:0], b3[31:24]}) ^ {rcon(rk_index_q), 24'h000000};
  assign prev_key_d = {b0, b1, b2, b3};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rk_data_q  <= '0;
      rk_index_q <= '0;
      rk_valid_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q    <= S_EMIT;
            rk_data_q  <= last_key;
            rk_index_q <= 4'(NR);
            rk_valid_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_EMIT: begin
          if (rk_ready) begin
            if (rk_index_q != 4'd0) begin
              rk_data_q  <= prev_key_d;
              rk_index_q <= rk_index_q - 4'd1;
            end else begin
              state_q    <= S_DONE;
              rk_valid_q <= 1'b0;
              done_q     <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= S_IDLE;
          rk_valid_q <= 1'b0;
          done_q     <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign rk_valid = rk_valid_q;
  assign rk_data  = rk_data_q;
  assign rk_index = rk_index_q;
  assign done     = done_q;

endmodule

// File: doc/inv_key_schedule.md
INV_KEY_SCHEDULE -- requirements
Module: inv_key_schedule

Interface
REQ-001 Parameter: NR, 10, number of AES rounds; only 10 (AES-128, NK=4) is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  request to begin; sampled only in IDLE.
REQ-005 last_key  input  128  round-10 key; word 0 is [127:96], word 3 is [31:0]; sampled with start.
REQ-006 busy  output  1  high in any state other than IDLE.
REQ-007 rk_valid  output  1  rk_data/rk_index hold a valid round key.
REQ-008 rk_ready  input  1  consumer accepts the round key when rk_valid && rk_ready.
REQ-009 rk_data  output  128  round key, same word order as last_key.
REQ-010 rk_index  output  4  round number of rk_data, 10 down to 0.
REQ-011 done  output  1  one-cycle pulse after round key 0 is accepted.

Function
REQ-012 The FSM SHALL have states IDLE, EMIT and DONE, encoded as 2 bits.
REQ-013 IDLE with start=1: SHALL load rk_data=last_key and rk_index=10, go to EMIT, and assert rk_valid on the next cycle (1-cycle latency).
REQ-014 IDLE with start=0: SHALL hold; rk_valid=0 and done=0.
REQ-015 In EMIT, rk_valid SHALL be 1, and rk_data/rk_index SHALL stay stable until the handshake.
REQ-016 Handshake in EMIT with rk_index>0: SHALL replace rk_data with the previous round key and decrement rk_index; rk_valid stays 1, giving 1 key per cycle when rk_ready is held high.
REQ-017 Previous-key derivation, with current words a0..a3 at round r: b3=a3^a2, b2=a2^a1, b1=a1^a0, b0=a0^SubWord(RotWord(b3))^Rcon(r).
REQ-018 RotWord SHALL be a cyclic left shift by 1 byte, and SubWord SHALL be the forward AES S-box applied bytewise.
REQ-019 Rcon(r) SHALL be {rc,24'h0} with rc for r=1..10 equal to 01,02,04,08,10,20,40,80,1b,36.
REQ-020 Handshake in EMIT with rk_index=0: SHALL go to DONE with rk_valid=0.
REQ-021 rk_data SHALL retain the round-0 key after that handshake.
REQ-022 DONE: SHALL assert done=1 and busy=1 for exactly 1 cycle, then go to IDLE.
REQ-023 start asserted while in EMIT or DONE SHALL be ignored; no restart and no key reload.
REQ-024 rk_ready=0 in EMIT SHALL stall indefinitely with all outputs stable.
REQ-025 rk_ready asserted while rk_valid=0 SHALL have no effect.
REQ-026 rk_index SHALL never wrap below 0.
REQ-027 The round-key computation SHALL be combinational from the rk_data register, with no additional pipeline stage.

Reset
REQ-028 rst=1 at a rising edge SHALL force IDLE, with rk_valid=0, done=0, busy=0, rk_data=0 and rk_index=0.
REQ-029 rst SHALL take priority over start and over any handshake, including mid-sequence.
REQ-030 After rst deasserts, the block SHALL accept a new start in the next cycle.

Verification
REQ-031 start with last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, rk_ready=1 -> keys index 10..0 on 11 consecutive cycles: index 9=ac7766f319fadc2128d12941575c006e, index 1=a0fafe1788542cb123a339392a6c7605, index 0=2b7e151628aed2a6abf7158809cf4f3c; done pulses 1 cycle after index 0.
REQ-032 start with last_key=b4ef5bcb3e92e21123e951cf6f8f188e -> index 1=62636363626363636263636362636363, index 0=00000000000000000000000000000000.
REQ-033 Randomly toggle rk_ready during REQ-031 -> identical key sequence, no skipped or duplicated index, and data stable while rk_valid&&!rk_ready.
REQ-034 Pulse start at index 5 -> sequence unaffected; only 1 done pulse.
REQ-035 Assert rst at index 4 -> next cycle busy=0, rk_valid=0, rk_data=0; then start with the REQ-032 key -> full correct sequence.
REQ-036 Hold start=1 continuously with rk_ready=1 -> back-to-back sequences: 11 keys, then done, then IDLE for 1 cycle, then the next rk_valid.
